// File: rtl/CDB_types.sv
// Common data bus shared types: lane count, register/ROB sizing
// and the result entry passed between FUs, the CDB and the ROB.
package CDB_types;

    localparam int CDB_NUM   = 5;
    localparam int P_REG_NUM = 64;
    localparam int ROB_DEPTH = 32;

    localparam int PD_W  = $clog2(P_REG_NUM);
    localparam int ROB_W = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic [PD_W-1:0]  pd;
        logic [31:0]      value;
        logic [ROB_W-1:0] rob_idx;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_result_queue.sv
// Per-FU circular result FIFO feeding the CDB arbiter.
// Pointers wrap naturally because DEPTH is a power of two.
module cdb_result_queue
    import CDB_types::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  cdb_entry_t       din,
    input  logic             pop,
    output cdb_entry_t       head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    cdb_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants up to CDB_NUM queue heads per cycle
// onto registered bus lanes, scanning FUs from rr_ptr with wraparound.
module cdb_arbiter
    import CDB_types::*;
#(
    parameter int NUM_FU      = 6,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [NUM_FU-1:0]   fu_valid,
    output logic [NUM_FU-1:0]   fu_ready,
    input  logic [PD_W-1:0]     fu_pd [NUM_FU],
    input  logic [31:0]         fu_result [NUM_FU],
    input  logic [ROB_W-1:0]    fu_rob_idx [NUM_FU],
    output logic [CDB_NUM-1:0]  cdb_we_array,
    output logic [PD_W-1:0]     cdb_pd_array [CDB_NUM],
    output logic [31:0]         cdb_funct_out_array [CDB_NUM],
    output logic [ROB_W-1:0]    cdb_rob_array [CDB_NUM]
);

    localparam int FU_W   = $clog2(NUM_FU);
    localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;
    localparam int LANE_W = $clog2(CDB_NUM + 1);

    localparam logic [CNT_W-1:0]  FULL   = CNT_W'(QUEUE_DEPTH);
    localparam logic [FU_W:0]     NFU    = (FU_W + 1)'(NUM_FU);
    localparam logic [FU_W-1:0]   LAST   = FU_W'(NUM_FU - 1);
    localparam logic [LANE_W-1:0] NLANES = LANE_W'(CDB_NUM);

    cdb_entry_t        din   [NUM_FU];
    cdb_entry_t        head  [NUM_FU];
    logic [CNT_W-1:0]  count [NUM_FU];
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] busy;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
        assign fu_ready[g] = count[g] < FULL;
        assign push[g]     = fu_valid[g] & fu_ready[g];
        assign busy[g]     = count[g] != '0;
        assign din[g]      = '{pd: fu_pd[g],
                               value: fu_result[g],
                               rob_idx: fu_rob_idx[g]};

        cdb_result_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[g]),
            .din   (din[g]),
            .pop   (pop[g]),
            .head  (head[g]),
            .count (count[g])
        );
    end

    logic [FU_W-1:0]    rr_ptr;
    logic [FU_W-1:0]    rr_next;
    logic [FU_W-1:0]    idx;
    logic [FU_W-1:0]    last;
    logic [FU_W:0]      sum;
    logic [LANE_W-1:0]  n;
    logic [CDB_NUM-1:0] sel_we;
    cdb_entry_t         sel [CDB_NUM];

    // k-th grant in scan order lands on lane k
    always_comb begin
        pop    = '0;
        sel_we = '0;
        sel    = '{default: '0};
        n      = '0;
        last   = rr_ptr;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            sum = {1'b0, rr_ptr} + (FU_W + 1)'(i);
            if (sum >= NFU) begin
                sum = sum - NFU;
            end
            idx = sum[FU_W-1:0];
            if (busy[idx] && n < NLANES) begin
                pop[idx]  = 1'b1;
                sel_we[n] = 1'b1;
                sel[n]    = head[idx];
                last      = idx;
                n         = n + 1'b1;
            end
        end
        if (n == '0) begin
            rr_next = rr_ptr;
        end else if (last == LAST) begin
            rr_next = '0;
        end else begin
            rr_next = last + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rr_ptr       <= '0;
            cdb_we_array <= '0;
            for (int k = 0; k < CDB_NUM; k++) begin
                cdb_pd_array[k]        <= '0;
                cdb_funct_out_array[k] <= '0;
                cdb_rob_array[k]       <= '0;
            end
        end else begin
            rr_ptr       <= rr_next;
            cdb_we_array <= sel_we;
            for (int k = 0; k < CDB_NUM; k++) begin
                cdb_pd_array[k]        <= sel[k].pd;
                cdb_funct_out_array[k] <= sel[k].value;
                cdb_rob_array[k]       <= sel[k].rob_idx;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: inputs driven and outputs checked
// on the falling edge, one task per scenario.
module tb_cdb_arbiter;
    import CDB_types::*;

    localparam int NUM_FU = 6;
    localparam int LW     = 1 + PD_W + 32 + ROB_W;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                flush = 1'b0;
    logic [NUM_FU-1:0]   fu_valid;
    logic [NUM_FU-1:0]   fu_ready;
    logic [PD_W-1:0]     fu_pd [NUM_FU];
    logic [31:0]         fu_result [NUM_FU];
    logic [ROB_W-1:0]    fu_rob_idx [NUM_FU];
    logic [CDB_NUM-1:0]  cdb_we_array;
    logic [PD_W-1:0]     cdb_pd_array [CDB_NUM];
    logic [31:0]         cdb_funct_out_array [CDB_NUM];
    logic [ROB_W-1:0]    cdb_rob_array [CDB_NUM];

    int tests = 0;
    int fails = 0;
    logic [LW-1:0]     exp_l [CDB_NUM];
    logic [NUM_FU-1:0] exp_rdy;

    cdb_arbiter #(.NUM_FU(NUM_FU), .QUEUE_DEPTH(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .fu_valid            (fu_valid),
        .fu_ready            (fu_ready),
        .fu_pd               (fu_pd),
        .fu_result           (fu_result),
        .fu_rob_idx          (fu_rob_idx),
        .cdb_we_array        (cdb_we_array),
        .cdb_pd_array        (cdb_pd_array),
        .cdb_funct_out_array (cdb_funct_out_array),
        .cdb_rob_array       (cdb_rob_array)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] ent(int pd, logic [31:0] val, int rob);
        return {1'b1, PD_W'(pd), val, ROB_W'(rob)};
    endfunction

    function automatic logic [LW-1:0] got(int k);
        return {cdb_we_array[k], cdb_pd_array[k],
                cdb_funct_out_array[k], cdb_rob_array[k]};
    endfunction

    task automatic idle();
        fu_valid = '0;
        flush    = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_pd[i]      = '0;
            fu_result[i]  = '0;
            fu_rob_idx[i] = '0;
        end
    endtask

    task automatic push(int fu, int pd, logic [31:0] val, int rob);
        fu_valid[fu]   = 1'b1;
        fu_pd[fu]      = PD_W'(pd);
        fu_result[fu]  = val;
        fu_rob_idx[fu] = ROB_W'(rob);
    endtask

    task automatic exp_clear();
        for (int k = 0; k < CDB_NUM; k++) exp_l[k] = '0;
        exp_rdy = '1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < NUM_FU; i++) push(i, i + 1, 32'h5A5A0000 + i, i);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            exp_clear();
            for (int k = 0; k < CDB_NUM; k++) begin
                tests++;
                if (got(k) !== exp_l[k]) begin
                    fails++;
                    $display("FAIL reset c%0d lane%0d: got %h, expected %h", c, k, got(k), exp_l[k]);
                end
            end
            tests++;
            if (fu_ready !== exp_rdy) begin
                fails++;
                $display("FAIL reset c%0d fu_ready: got %b, expected %b", c, fu_ready, exp_rdy);
            end
        end
    endtask

    task automatic test_single();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_clear();
            if (c == 2) exp_l[0] = ent(7, 32'hDEADBEEF, 3);
            for (int k = 0; k < CDB_NUM; k++) begin
                tests++;
                if (got(k) !== exp_l[k]) begin
                    fails++;
                    $display("FAIL single c%0d lane%0d: got %h, expected %h", c, k, got(k), exp_l[k]);
                end
            end
            tests++;
            if (fu_ready !== exp_rdy) begin
                fails++;
                $display("FAIL single c%0d fu_ready: got %b, expected %b", c, fu_ready, exp_rdy);
            end
            idle();
            if (c == 0) push(2, 7, 32'hDEADBEEF, 3);
        end
    endtask

    task automatic test_all_fu();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_clear();
            if (c == 3) begin
                for (int k = 0; k < 5; k++) exp_l[k] = ent(10 + k, 32'h100 + k, k);
            end
            if (c == 4) exp_l[0] = ent(15, 32'h105, 5);
            if (c == 6) begin
                exp_l[0] = ent(20, 32'h20, 20);
                exp_l[1] = ent(25, 32'h25, 21);
            end
            for (int k = 0; k < CDB_NUM; k++) begin
                tests++;
                if (got(k) !== exp_l[k]) begin
                    fails++;
                    $display("FAIL all_fu c%0d lane%0d: got %h, expected %h", c, k, got(k), exp_l[k]);
                end
            end
            tests++;
            if (fu_ready !== exp_rdy) begin
                fails++;
                $display("FAIL all_fu c%0d fu_ready: got %b, expected %b", c, fu_ready, exp_rdy);
            end
            idle();
            if (c == 0) flush = 1'b1;
            if (c == 1) begin
                for (int i = 0; i < NUM_FU; i++) push(i, 10 + i, 32'h100 + i, i);
            end
            if (c == 4) begin
                push(0, 20, 32'h20, 20);
                push(5, 25, 32'h25, 21);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            exp_clear();
            if (c >= 2 && c <= 5) exp_l[0] = ent(c - 1, 32'hA0 + c - 2, c - 2);
            for (int k = 0; k < CDB_NUM; k++) begin
                tests++;
                if (got(k) !== exp_l[k]) begin
                    fails++;
                    $display("FAIL back_to_back c%0d lane%0d: got %h, expected %h", c, k, got(k), exp_l[k]);
                end
            end
            tests++;
            if (fu_ready !== exp_rdy) begin
                fails++;
                $display("FAIL back_to_back c%0d fu_ready: got %b, expected %b", c, fu_ready, exp_rdy);
            end
            idle();
            if (c <= 3) push(0, c + 1, 32'hA0 + c, c);
        end
    endtask

    task automatic test_backpressure();
        int fu;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_clear();
            case (c)
                2: exp_l[0] = ent(21, 32'hA1, 1);
                3: begin
                    for (int k = 0; k < 5; k++) begin
                        fu = (2 + k) % NUM_FU;
                        exp_l[k] = ent(30 + fu, 32'h100 + fu, 10 + fu);
                    end
                    exp_rdy = 6'b111101;
                end
                4: exp_l[0] = ent(22, 32'hB1, 2);
                5: exp_l[0] = ent(23, 32'hC1, 4);
                6: exp_l[0] = ent(24, 32'hD1, 5);
                default: ;
            endcase
            for (int k = 0; k < CDB_NUM; k++) begin
                tests++;
                if (got(k) !== exp_l[k]) begin
                    fails++;
                    $display("FAIL backpressure c%0d lane%0d: got %h, expected %h", c, k, got(k), exp_l[k]);
                end
            end
            tests++;
            if (fu_ready !== exp_rdy) begin
                fails++;
                $display("FAIL backpressure c%0d fu_ready: got %b, expected %b", c, fu_ready, exp_rdy);
            end
            idle();
            case (c)
                0: push(1, 21, 32'hA1, 1);
                1: begin
                    for (int i = 0; i < NUM_FU; i++) begin
                        if (i != 1) push(i, 30 + i, 32'h100 + i, 10 + i);
                    end
                    push(1, 22, 32'hB1, 2);
                end
                2: push(1, 23, 32'hC1, 4);
                3, 4: push(1, 24, 32'hD1, 5);
                default: ;
            endcase
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            exp_clear();
            if (c == 5) begin
                exp_l[0] = ent(50, 32'h55, 26);
                exp_l[1] = ent(51, 32'h66, 27);
            end
            for (int k = 0; k < CDB_NUM; k++) begin
                tests++;
                if (got(k) !== exp_l[k]) begin
                    fails++;
                    $display("FAIL flush c%0d lane%0d: got %h, expected %h", c, k, got(k), exp_l[k]);
                end
            end
            tests++;
            if (fu_ready !== exp_rdy) begin
                fails++;
                $display("FAIL flush c%0d fu_ready: got %b, expected %b", c, fu_ready, exp_rdy);
            end
            idle();
            case (c)
                0: for (int i = 0; i < 4; i++) push(i, 40 + i, 32'h200 + i, 20 + i);
                1: begin
                    flush = 1'b1;
                    push(5, 45, 32'h205, 25);
                end
                3: begin
                    push(0, 50, 32'h55, 26);
                    push(5, 51, 32'h66, 27);
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_pd_zero();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_clear();
            if (c == 2) exp_l[0] = ent(0, 32'd5, 9);
            for (int k = 0; k < CDB_NUM; k++) begin
                tests++;
                if (got(k) !== exp_l[k]) begin
                    fails++;
                    $display("FAIL pd_zero c%0d lane%0d: got %h, expected %h", c, k, got(k), exp_l[k]);
                end
            end
            tests++;
            if (fu_ready !== exp_rdy) begin
                fails++;
                $display("FAIL pd_zero c%0d fu_ready: got %b, expected %b", c, fu_ready, exp_rdy);
            end
            idle();
            if (c == 0) push(0, 0, 32'd5, 9);
        end
    endtask

    task automatic test_rst_override();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp_clear();
            for (int k = 0; k < CDB_NUM; k++) begin
                tests++;
                if (got(k) !== exp_l[k]) begin
                    fails++;
                    $display("FAIL rst_override c%0d lane%0d: got %h, expected %h", c, k, got(k), exp_l[k]);
                end
            end
            tests++;
            if (fu_ready !== exp_rdy) begin
                fails++;
                $display("FAIL rst_override c%0d fu_ready: got %b, expected %b", c, fu_ready, exp_rdy);
            end
            idle();
            rst = 1'b0;
            if (c == 0) push(3, 12, 32'h77, 7);
            if (c == 1) begin
                rst = 1'b1;
                push(4, 13, 32'h88, 8);
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_all_fu();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_pd_zero();
        test_rst_override();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
